// File: rtl/riscv_register_file_sb.sv
// -----------------------------------------------------------------------------
// riscv_register_file_sb
//
// RISC-V integer register file with NUM_READ_PORTS combinational read ports,
// one write (writeback) port, optional write-to-read bypass and a per-register
// busy scoreboard used to track destinations of multi-cycle operations.
//
// Parameters
//   XLEN            register width in bits
//   NUM_REGS        architectural register count, 16 (RV32E) or 32 (RV32I/RV64I)
//   NUM_READ_PORTS  number of read ports, 1..4
//   BYPASS          1: a committing write is forwarded to same-cycle reads
//
// Ports
//   clock            rising-edge clock
//   reset_n          asynchronous active-low reset (clears array and scoreboard)
//   rs_addr          read addresses, port p at [5p+4:5p]
//   rs_data          read data, port p at [XLEN*p +: XLEN]
//   rs_busy          per read port: addressed register has a pending write
//   rd_addr          writeback destination
//   rd_enable_write  writeback strobe
//   rd_data          writeback data
//   rsv_valid        reservation request for rsv_addr
//   rsv_addr         register to reserve
//   rsv_ready        reservation accepted this cycle
//   busy_vector      scoreboard state, bit r = register r busy
//
// Reservation handshake (rsv_valid / rsv_ready):
//   A reservation takes effect on the rising edge where rsv_valid and
//   rsv_ready are both 1. rsv_ready is a pure function of rsv_addr, the
//   scoreboard and the writeback port; it never depends on rsv_valid. A
//   requester that sees rsv_ready=0 holds rsv_valid and rsv_addr steady
//   until rsv_ready=1. Reserving x0 is always accepted and changes nothing;
//   reserving an address >= NUM_REGS is always refused.
// -----------------------------------------------------------------------------
module riscv_register_file_sb #(
  parameter int XLEN           = 32,
  parameter int NUM_REGS       = 32,
  parameter int NUM_READ_PORTS = 2,
  parameter int BYPASS         = 1
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic [5*NUM_READ_PORTS-1:0]    rs_addr,
  output logic [XLEN*NUM_READ_PORTS-1:0] rs_data,
  output logic [NUM_READ_PORTS-1:0]      rs_busy,
  input  logic [4:0]                     rd_addr,
  input  logic                           rd_enable_write,
  input  logic [XLEN-1:0]                rd_data,
  input  logic                           rsv_valid,
  input  logic [4:0]                     rsv_addr,
  output logic                           rsv_ready,
  output logic [NUM_REGS-1:0]            busy_vector
);

  // Index width into the physical array. Only legal addresses are ever used
  // to index, so the low IDXW bits fully identify the register.
  localparam int IDXW = $clog2(NUM_REGS);

  typedef logic [IDXW-1:0] idx_t;

  // Legality uses all five address bits: with NUM_REGS=16 an address such as
  // x20 must not alias onto x4, so the upper bit is compared, never dropped.
  function automatic logic f_legal(input logic [4:0] a);
    return ({1'b0, a} < 6'(NUM_REGS));
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0]     r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_busy;

  // ---------------------------------------------------------------------------
  // Writeback decode
  // ---------------------------------------------------------------------------
  logic w_commit;
  idx_t w_wr_idx;

  assign w_wr_idx = rd_addr[IDXW-1:0];

  // Gated by reset_n so that nothing is forwarded and no release is seen
  // while reset is held; the array is being cleared at that time.
  assign w_commit = reset_n & rd_enable_write & f_legal(rd_addr) &
                    (rd_addr != 5'd0);

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic                w_rsv_legal;
  idx_t                w_rsv_idx;
  logic [NUM_REGS-1:0] w_clr;
  logic [NUM_REGS-1:0] w_set;
  logic [NUM_REGS-1:0] w_busy_next;

  assign w_rsv_legal = f_legal(rsv_addr);
  assign w_rsv_idx   = rsv_addr[IDXW-1:0];

  // A busy register being released this same cycle may be re-reserved: the
  // older writer retires on this edge, so the new reservation has no WAW
  // hazard against it.
  assign rsv_ready = w_rsv_legal &
                     ((rsv_addr == 5'd0) | ~r_busy[w_rsv_idx] | w_clr[w_rsv_idx]);

  always_comb begin
    w_clr = '0;
    w_set = '0;
    if (w_commit) begin
      w_clr[w_wr_idx] = 1'b1;
    end
    // x0 is accepted but never marked busy, so bit 0 stays 0 forever.
    if (rsv_valid && rsv_ready && (rsv_addr != 5'd0)) begin
      w_set[w_rsv_idx] = 1'b1;
    end
  end

  // Release first, then reserve: a simultaneous release and re-reserve of
  // the same register leaves it busy.
  assign w_busy_next = (r_busy & ~w_clr) | w_set;

  assign busy_vector = r_busy;

  // ---------------------------------------------------------------------------
  // Sequential update of array and scoreboard
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        r_regs[r] <= '0;
      end
      r_busy <= '0;
    end else begin
      if (w_commit) begin
        r_regs[w_wr_idx] <= rd_data;
      end
      r_busy <= w_busy_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports: combinational, zero latency.
  // x0 and illegal addresses read 0 and are never busy. With bypass enabled a
  // register being written this cycle returns the incoming data and reports
  // not busy, since the pending value is exactly what is being written now.
  // ---------------------------------------------------------------------------
  for (genvar gp = 0; gp < NUM_READ_PORTS; gp++) begin : g_read
    logic [4:0] w_ra;
    idx_t       w_ri;
    logic       w_ok;
    logic       w_hit;

    assign w_ra  = rs_addr[5*gp +: 5];
    assign w_ri  = w_ra[IDXW-1:0];
    assign w_ok  = f_legal(w_ra) & (w_ra != 5'd0);
    assign w_hit = (BYPASS != 0) & w_commit & (w_ra == rd_addr);

    assign rs_data[XLEN*gp +: XLEN] = !w_ok ? '0 :
                                      (w_hit ? rd_data : r_regs[w_ri]);
    assign rs_busy[gp] = w_ok & ~w_hit & r_busy[w_ri];
  end

endmodule
